// File: rtl/uop_pkg.sv
// Shared types, constants and helpers for the uop datapath and its collector.
package uop_pkg;

    // The wrapper's own input and output registers.
    localparam int UOP_WRAP_IO_LAT = 2;

    // Default widths of the datapath.
    localparam int UOP_W     = 64;
    localparam int UOP_TAG_W = 4;

    // Result entry in the default configuration. Parameterised users declare a
    // struct of the same shape locally and pass it to uop_res_fifo as its type.
    typedef struct packed {
        logic [UOP_TAG_W-1:0] tag;
        logic [UOP_W-1:0]     data;
    } uop_res_t;

    // Core latency: one edge for each enabled register among the pipe stages.
    // Integrators derive LAT = UOP_WRAP_IO_LAT + uop_block_lat(...).
    function automatic int unsigned uop_block_lat(input int unsigned pipe_stages,
                                                  input logic [31:0] ff_mask);
        int unsigned lat;
        lat = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < pipe_stages && ff_mask[i]) lat++;
        end
        return lat;
    endfunction

endpackage

// File: rtl/uop_result_collector_if.sv
// Issue and result channels of the uop result collector.
interface uop_result_collector_if #(
    parameter int W     = 64,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_src;
    logic [$clog2(W)-1:0] in_shamt;
    logic [TAG_W-1:0]     in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    logic [TAG_W-1:0]     out_tag;

    // Producer/consumer side.
    modport master (
        output in_valid, in_src, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // Collector side.
    modport slave (
        input  in_valid, in_src, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/uop_res_fifo.sv
// Circular result buffer with occupancy count; head is read combinationally.
module uop_res_fifo
    import uop_pkg::*;
#(
    parameter type T     = uop_res_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic empty,
    output logic full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] occ;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty  = (occ == '0);
    assign full   = (occ == CW'(DEPTH));
    assign pop_ok = pop && !empty;
    assign rdata  = mem[rd_ptr];

    // Storage is not reset; a write into a full buffer is legal only alongside a pop.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)   wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop_ok})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
            assert (!(push && full && !pop_ok))
                else $error("uop_res_fifo: write into full buffer");
        end
    end

endmodule

// File: rtl/uop_result_collector.sv
// Completion stage for the fixed-latency uop wrapper: issue handshake,
// valid/tag delay line matching the wrapper latency, credit-guarded result FIFO.
module uop_result_collector
    import uop_pkg::*;
#(
    parameter int W     = 64,
    parameter int LAT   = 3,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    uop_result_collector_if.slave        bus,
    output logic [W-1:0]                 src_o,
    output logic [$clog2(W)-1:0]         shamt_o,
    input  logic [W-1:0]                 dst_i,
    output logic [$clog2(DEPTH+1)-1:0]   in_flight,
    output logic [31:0]                  issued_cnt,
    output logic [31:0]                  retired_cnt
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     data;
    } res_t;

    logic             fire;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [LAT-1:0]   dl_valid;
    logic [TAG_W-1:0] dl_tag [LAT];
    res_t             wr_res;
    res_t             rd_res;

    // The wrapper registers its inputs every cycle, so operands pass straight through.
    assign src_o   = bus.in_src;
    assign shamt_o = bus.in_shamt;

    // Credits come from registered in_flight only; out_ready never reaches in_ready.
    assign bus.in_ready  = rst_n && (in_flight < CW'(DEPTH));
    assign fire          = bus.in_valid && bus.in_ready;
    assign bus.out_valid = !fifo_empty;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_data  = rd_res.data;
    assign bus.out_tag   = rd_res.tag;

    assign wr_res = '{tag: dl_tag[LAT-1], data: dst_i};

    // Valid delay line; clearing it on reset drops results still inside the wrapper.
    always_ff @(posedge clk) begin
        if (!rst_n) dl_valid <= '0;
        else        dl_valid <= {dl_valid[LAT-2:0], fire};
    end

    // Tag delay line, unqualified; only meaningful where the matching valid is set.
    always_ff @(posedge clk) begin
        dl_tag[0] <= bus.in_tag;
        for (int unsigned i = 1; i < unsigned'(LAT); i++) dl_tag[i] <= dl_tag[i-1];
    end

    // Credit count plus wrapping issue/retire counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_flight   <= '0;
            issued_cnt  <= '0;
            retired_cnt <= '0;
        end else begin
            case ({fire, pop})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase
            issued_cnt  <= issued_cnt + 32'(fire);
            retired_cnt <= retired_cnt + 32'(pop);
        end
    end

    uop_res_fifo #(
        .T     (res_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dl_valid[LAT-1]),
        .wdata (wr_res),
        .pop   (pop),
        .rdata (rd_res),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Full-but-writing is legal only with a simultaneous pop; the FIFO asserts on it.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_uop_result_collector.sv
// Bench for uop_result_collector with a shift-left wrapper model and a queue-based
// reference of issued-but-unretired results.
module tb_uop_result_collector;
    localparam int W     = 64;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int SW    = $clog2(W);

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [W-1:0]               src_o;
    logic [SW-1:0]              shamt_o;
    logic [W-1:0]               dst_i;
    logic [$clog2(DEPTH+1)-1:0] in_flight;
    logic [31:0]                issued_cnt;
    logic [31:0]                retired_cnt;

    uop_result_collector_if #(.W(W), .TAG_W(TAG_W)) bus ();

    uop_result_collector #(
        .W     (W),
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .src_o       (src_o),
        .shamt_o     (shamt_o),
        .dst_i       (dst_i),
        .in_flight   (in_flight),
        .issued_cnt  (issued_cnt),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    // Wrapper model: dst = src << shamt, LAT edges after the operands are sampled.
    logic [W-1:0] wpipe [LAT];
    always @(posedge clk) begin
        wpipe[0] <= src_o << shamt_o;
        for (int i = 1; i < LAT; i++) wpipe[i] <= wpipe[i-1];
    end
    assign dst_i = wpipe[LAT-1];

    // Reference: every accepted op in issue order with the cycle it becomes visible.
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     data;
        int               vis;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    logic [31:0] m_issued = '0;
    logic [31:0] m_retired = '0;
    int          total = 0;
    int          passed = 0;
    int          failed = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare, advance the model.
    task automatic step(input logic v, input logic [W-1:0] src, input logic [SW-1:0] sh,
                        input logic [TAG_W-1:0] tag, input logic ordy);
        logic m_ready;
        logic m_valid;
        bus.in_valid  = v;
        bus.in_src    = src;
        bus.in_shamt  = sh;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        #1;
        m_ready = (q.size() < DEPTH);
        m_valid = (q.size() > 0) && (q[0].vis <= cyc);
        chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        chk("in_flight", 64'(in_flight), 64'(q.size()));
        chk("issued_cnt", 64'(issued_cnt), 64'(m_issued));
        chk("retired_cnt", 64'(retired_cnt), 64'(m_retired));
        if (m_valid) begin
            chk("out_data", bus.out_data, q[0].data);
            chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
        end
        if (m_valid && ordy) begin
            void'(q.pop_front());
            m_retired++;
        end
        if (v && m_ready) begin
            q.push_back('{tag: tag, data: src << sh, vis: cyc + LAT + 1});
            m_issued++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, ordy);
    endtask

    // One reset edge; in_ready must be low while rst_n is low.
    task automatic pulse_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        cyc++;
        q.delete();
        m_issued  = '0;
        m_retired = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_src    = '0;
        bus.in_shamt  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        pulse_reset();

        // Reset state, then a single op: 0x5 << 1 = 0xA, tag 1.
        idle(1, 1'b1);
        step(1'b1, 64'h5, 6'd1, 4'd1, 1'b1);
        idle(6, 1'b1);

        // Streaming, tags 0..15.
        for (int i = 0; i < 16; i++)
            step(1'b1, 64'(i * 3 + 1), 6'(i), 4'(i), 1'b1);
        idle(8, 1'b1);

        // Backpressure: fill, then release.
        for (int i = 0; i < 8; i++)
            step(1'b1, 64'h100 + 64'(i), 6'd4, 4'(i), 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 64'h200 + 64'(i), 6'd2, 4'(i + 8), 1'b1);
        idle(8, 1'b1);

        // Reset mid-stream with two results buffered and two inside the wrapper.
        for (int i = 0; i < 4; i++)
            step(1'b1, 64'hABC0 + 64'(i), 6'd0, 4'(i + 3), 1'b0);
        idle(1, 1'b0);
        pulse_reset();
        idle(LAT + 2, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(1'($urandom), {$urandom, $urandom}, 6'($urandom_range(0, W - 1)),
                 4'($urandom), 1'($urandom_range(0, 3) != 0));
        idle(10, 1'b1);

        // issued_cnt wraps from 0xFFFFFFFF to 0 on the next fire.
        force dut.issued_cnt = 32'hFFFF_FFFF;
        m_issued = 32'hFFFF_FFFF;
        idle(1, 1'b1);
        release dut.issued_cnt;
        step(1'b1, 64'h7, 6'd3, 4'd9, 1'b1);
        idle(6, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
